led_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the 8-row × 4-column LED matrix on the iCEFUN board. It owns the row and column pins, steps through the four columns, and applies 3-bit PWM brightness within each column slot. It accepts new frame contents from the SoC or debug logic through a valid/ready handshake. Updates are double-buffered and committed only at frame boundaries, so a frame never tears.

---
 rtl/led_scan_ctrl.sv | 155 +++++++++++++++
 tb/tb_led_scan_ctrl.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl: 8x4 LED matrix scanner with 3-bit PWM.
// Frame updates are double-buffered and commit only at frame boundaries.
//
// Ports:
//   clk, resetn        clock, async active-low reset
//   en                 scan enable (low: LEDs off, counters hold)
//   upd_valid/ready    frame update handshake
//   upd_data[31:0]     frame, bits [8c+7:8c] = column c, bit r = row r
//   upd_pwm[2:0]       brightness 0..7
//   frame_start        1-cycle pulse at column 0 phase 0
//   led_row[7:0]       row drive, active-low
//   led_col[3:0]       column select, one-hot-low
//
// Build option: LED_SCAN_BLANK_EN keeps phase 0 dark (max duty 7/8).
// Without it the lit window is phase <= pwm (duty (pwm+1)/8).
`timescale 1ns/1ps

module led_scan_ctrl #(
  parameter int DIV = 186
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        en,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [31:0] upd_data,
  input  logic [2:0]  upd_pwm,
  output logic        frame_start,
  output logic [7:0]  led_row,
  output logic [3:0]  led_col
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  localparam logic [0:0] S_EMPTY   = 1'b0;
  localparam logic [0:0] S_PENDING = 1'b1;

  logic [PW-1:0] pre;
  logic [2:0]    phase;
  logic [1:0]    col;
  logic          run;
  logic [0:0]    state;

  logic [31:0]   pend_data;
  logic [2:0]    pend_pwm;
  logic [31:0]   act_data;
  logic [2:0]    act_pwm;

  logic          step;
  logic          tick;
  logic          boundary;
  logic          accept;
  logic          lit;
  logic [7:0]    col_bits;
  logic [7:0]    row_n;
  logic [3:0]    col_n;
  logic          at_start;

  // run holds the scan off for the first edge after reset so the
  // first column-0 slot appears from the second edge with full length.
  assign step     = en & run;
  assign tick     = step & (pre == PRE_MAX);
  assign boundary = tick & (col == 2'd3) & (phase == 3'd7);

  assign upd_ready = (state == S_EMPTY);
  assign accept    = upd_valid & upd_ready;

  assign col_bits = act_data[{col, 3'b000} +: 8];

`ifdef LED_SCAN_BLANK_EN
  assign lit = (phase != 3'd0) & (phase <= act_pwm);
`else
  assign lit = (phase <= act_pwm);
`endif

  assign row_n    = ~(col_bits & {8{lit}});
  assign col_n    = ~(4'b0001 << col);
  assign at_start = (pre == '0) & (phase == 3'd0) & (col == 2'd0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run <= 1'b0;
    end else begin
      run <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pre   <= '0;
      phase <= 3'd0;
      col   <= 2'd0;
    end else if (step) begin
      if (pre == PRE_MAX) begin
        pre <= '0;
      end else begin
        pre <= pre + 1'b1;
      end
      if (tick) begin
        phase <= phase + 3'd1;
        if (phase == 3'd7) begin
          col <= col + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led_row     <= 8'hFF;
      led_col     <= 4'hF;
      frame_start <= 1'b0;
    end else if (step) begin
      led_row     <= row_n;
      led_col     <= col_n;
      frame_start <= at_start;
    end else begin
      led_row     <= 8'hFF;
      led_col     <= 4'hF;
      frame_start <= 1'b0;
    end
  end

  // An accept on a boundary tick lands in pending only; commit needs
  // a later boundary, so a frame never shows half-old, half-new data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_EMPTY;
      pend_data <= 32'd0;
      pend_pwm  <= 3'd0;
      act_data  <= 32'd0;
      act_pwm   <= 3'd7;
    end else begin
      unique case (1'b1)
        (state == S_EMPTY): begin
          if (accept) begin
            pend_data <= upd_data;
            pend_pwm  <= upd_pwm;
            state     <= S_PENDING;
          end
        end
        (state == S_PENDING): begin
          if (boundary) begin
            act_data <= pend_data;
            act_pwm  <= pend_pwm;
            state    <= S_EMPTY;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// tb_led_scan_ctrl: randomized bench for led_scan_ctrl.
// Reference model tracks frame position and buffers with plain arithmetic.
`timescale 1ns/1ps

module tb_led_scan_ctrl;

  localparam int DIV   = 2;
  localparam int SLOT  = 8 * DIV;
  localparam int FRAME = 32 * DIV;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        en = 1'b0;
  logic        upd_valid = 1'b0;
  logic        upd_ready;
  logic [31:0] upd_data = 32'd0;
  logic [2:0]  upd_pwm = 3'd0;
  logic        frame_start;
  logic [7:0]  led_row;
  logic [3:0]  led_col;

  led_scan_ctrl #(.DIV(DIV)) dut (
    .clk(clk),
    .resetn(resetn),
    .en(en),
    .upd_valid(upd_valid),
    .upd_ready(upd_ready),
    .upd_data(upd_data),
    .upd_pwm(upd_pwm),
    .frame_start(frame_start),
    .led_row(led_row),
    .led_col(led_col)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // reference model state
  logic        m_started = 1'b0;
  int          m_pos = 0;
  logic        m_ready = 1'b1;
  logic        m_acc = 1'b0;
  logic [31:0] m_pend = 32'd0;
  logic [2:0]  m_pend_pwm = 3'd0;
  logic [31:0] m_act = 32'd0;
  logic [2:0]  m_act_pwm = 3'd7;
  logic [7:0]  e_row = 8'hFF;
  logic [3:0]  e_col = 4'hF;
  logic        e_fs = 1'b0;
  logic        m_bnd;
  int          mc, mph;
  logic [3:0]  m_one = 4'b0001;

  function automatic logic lit_at(int ph, int pwm);
`ifdef LED_SCAN_BLANK_EN
    return (ph >= 1) && (ph <= pwm);
`else
    return ph < pwm + 1;
`endif
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_started  = 1'b0;
      m_pos      = 0;
      m_ready    = 1'b1;
      m_acc      = 1'b0;
      m_pend     = 32'd0;
      m_pend_pwm = 3'd0;
      m_act      = 32'd0;
      m_act_pwm  = 3'd7;
      e_row      = 8'hFF;
      e_col      = 4'hF;
      e_fs       = 1'b0;
    end else begin
      m_bnd = 1'b0;
      if (m_started && en) begin
        mc    = m_pos / SLOT;
        mph   = (m_pos / DIV) % 8;
        e_col = ~(m_one << mc);
        e_row = 8'hFF;
        for (int r = 0; r < 8; r++)
          if (m_act[8*mc+r] && lit_at(mph, int'(m_act_pwm)))
            e_row[r] = 1'b0;
        e_fs  = (m_pos == 0);
        m_bnd = (m_pos == FRAME - 1);
        m_pos = (m_pos + 1) % FRAME;
      end else begin
        e_row = 8'hFF;
        e_col = 4'hF;
        e_fs  = 1'b0;
      end
      m_started = 1'b1;
      m_acc = upd_valid && m_ready;
      if (!m_ready && m_bnd) begin
        m_act     = m_pend;
        m_act_pwm = m_pend_pwm;
        m_ready   = 1'b1;
      end else if (m_acc) begin
        m_pend     = upd_data;
        m_pend_pwm = upd_pwm;
        m_ready    = 1'b0;
      end
    end
  end

  task automatic test_reset();
    int first, period;
    resetn = 1'b0;
    en = 1'b0;
    upd_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_chk++;
      if ({frame_start, upd_ready, led_col, led_row} !== {1'b0, 1'b1, 4'hF, 8'hFF})
        $display("FAIL reset_hold got=%h exp=%h",
                 {frame_start, upd_ready, led_col, led_row}, {1'b0, 1'b1, 4'hF, 8'hFF});
      else n_pass++;
    end
    resetn = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_chk++;
      if ({frame_start, upd_ready, led_col, led_row} !== {e_fs, m_ready, e_col, e_row})
        $display("FAIL reset_run got=%h exp=%h t=%0t",
                 {frame_start, upd_ready, led_col, led_row}, {e_fs, m_ready, e_col, e_row}, $time);
      else n_pass++;
    end
    upd_data = 32'hFFFF_FFFF;
    upd_pwm = 3'd7;
    upd_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      upd_valid = 1'b0;
      n_chk++;
      if ({frame_start, upd_ready, led_col, led_row} !== {e_fs, m_ready, e_col, e_row})
        $display("FAIL reset_pend got=%h exp=%h t=%0t",
                 {frame_start, upd_ready, led_col, led_row}, {e_fs, m_ready, e_col, e_row}, $time);
      else n_pass++;
    end
    #2 resetn = 1'b0;
    #1;
    n_chk++;
    if ({frame_start, upd_ready, led_col, led_row} !== {1'b0, 1'b1, 4'hF, 8'hFF})
      $display("FAIL reset_async got=%h exp=%h",
               {frame_start, upd_ready, led_col, led_row}, {1'b0, 1'b1, 4'hF, 8'hFF});
    else n_pass++;
    @(negedge clk);
    resetn = 1'b1;
    first = -1;
    period = -1;
    for (int i = 0; i < 3 * FRAME && period < 0; i++) begin
      @(negedge clk);
      n_chk++;
      if ({frame_start, upd_ready, led_col, led_row} !== {e_fs, m_ready, e_col, e_row})
        $display("FAIL reset_after got=%h exp=%h t=%0t",
                 {frame_start, upd_ready, led_col, led_row}, {e_fs, m_ready, e_col, e_row}, $time);
      else n_pass++;
      if (frame_start === 1'b1) begin
        if (first < 0) first = i;
        else period = i - first;
      end
    end
    n_chk++;
    if (first !== 1 || period !== FRAME)
      $display("FAIL frame_period got first=%0d period=%0d exp first=1 period=%0d",
               first, period, FRAME);
    else n_pass++;
  endtask

  task automatic test_scan();
    int fs_wait;
    logic [3:0] one = 4'b0001;
    logic [3:0] xc;
    en = 1'b1;
    upd_data = $urandom;
    upd_pwm = 3'($urandom);
    upd_valid = 1'b1;
    @(negedge clk);
    upd_valid = 1'b0;
    fs_wait = 0;
    while (frame_start !== 1'b1 && fs_wait < 2 * FRAME) begin
      @(negedge clk);
      fs_wait++;
    end
    for (int i = 0; i < FRAME; i++) begin
      xc = ~(one << (i / SLOT));
      n_chk++;
      if (led_col !== xc)
        $display("FAIL scan_col i=%0d got=%h exp=%h", i, led_col, xc);
      else n_pass++;
      n_chk++;
      if ({frame_start, upd_ready, led_col, led_row} !== {e_fs, m_ready, e_col, e_row})
        $display("FAIL scan_model got=%h exp=%h t=%0t",
                 {frame_start, upd_ready, led_col, led_row}, {e_fs, m_ready, e_col, e_row}, $time);
      else n_pass++;
      @(negedge clk);
    end
    n_chk++;
    if (frame_start !== 1'b1)
      $display("FAIL scan_next_fs got=%b exp=1", frame_start);
    else n_pass++;
  endtask

  task automatic test_pwm();
    int w, lit_cnt, other;
    w = 0;
    while (upd_ready !== 1'b1 && w < 3 * FRAME) begin
      @(negedge clk);
      w++;
    end
    upd_data = 32'h0000_00FF;
    upd_pwm = 3'd3;
    upd_valid = 1'b1;
    @(negedge clk);
    upd_valid = 1'b0;
    w = 0;
    while (upd_ready !== 1'b1 && w < 3 * FRAME) begin
      @(negedge clk);
      w++;
    end
    w = 0;
    while (frame_start !== 1'b1 && w < 2 * FRAME) begin
      @(negedge clk);
      w++;
    end
    lit_cnt = 0;
    other = 0;
    for (int i = 0; i < FRAME; i++) begin
      n_chk++;
      if ({frame_start, upd_ready, led_col, led_row} !== {e_fs, m_ready, e_col, e_row})
        $display("FAIL pwm_model got=%h exp=%h t=%0t",
                 {frame_start, upd_ready, led_col, led_row}, {e_fs, m_ready, e_col, e_row}, $time);
      else n_pass++;
      if (led_col === 4'hE && led_row === 8'h00) lit_cnt++;
      if (led_col !== 4'hE && led_row !== 8'hFF) other++;
      @(negedge clk);
    end
    n_chk++;
`ifdef LED_SCAN_BLANK_EN
    if (lit_cnt !== 3 * DIV || other !== 0)
      $display("FAIL pwm_duty got lit=%0d other=%0d exp lit=%0d other=0",
               lit_cnt, other, 3 * DIV);
`else
    if (lit_cnt !== 4 * DIV || other !== 0)
      $display("FAIL pwm_duty got lit=%0d other=%0d exp lit=%0d other=0",
               lit_cnt, other, 4 * DIV);
`endif
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int w, rdy_seen;
    w = 0;
    while (upd_ready !== 1'b1 && w < 3 * FRAME) begin
      @(negedge clk);
      w++;
    end
    upd_data = $urandom;
    upd_pwm = 3'($urandom_range(1, 7));
    upd_valid = 1'b1;
    @(negedge clk);
    n_chk++;
    if (upd_ready !== 1'b0 || m_acc !== 1'b1)
      $display("FAIL bp_accept_a got ready=%b exp=0", upd_ready);
    else n_pass++;
    upd_data = $urandom;
    upd_pwm = 3'($urandom_range(1, 7));
    rdy_seen = 0;
    w = 0;
    do begin
      @(negedge clk);
      w++;
      n_chk++;
      if ({frame_start, upd_ready, led_col, led_row} !== {e_fs, m_ready, e_col, e_row})
        $display("FAIL bp_model got=%h exp=%h t=%0t",
                 {frame_start, upd_ready, led_col, led_row}, {e_fs, m_ready, e_col, e_row}, $time);
      else n_pass++;
      if (upd_ready === 1'b1) rdy_seen++;
    end while (!m_acc && w < 3 * FRAME);
    upd_valid = 1'b0;
    n_chk++;
    if (rdy_seen !== 1 || upd_ready !== 1'b0)
      $display("FAIL bp_accept_b got ready_cycles=%0d ready=%b exp 1 and 0",
               rdy_seen, upd_ready);
    else n_pass++;
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      @(negedge clk);
      n_chk++;
      if ({frame_start, upd_ready, led_col, led_row} !== {e_fs, m_ready, e_col, e_row})
        $display("FAIL bp_show got=%h exp=%h t=%0t",
                 {frame_start, upd_ready, led_col, led_row}, {e_fs, m_ready, e_col, e_row}, $time);
      else n_pass++;
    end
  endtask

  task automatic test_collision();
    int w;
    w = 0;
    while (upd_ready !== 1'b1 && w < 3 * FRAME) begin
      @(negedge clk);
      w++;
    end
    w = 0;
    while (!(m_started && m_pos == FRAME - 1) && w < 2 * FRAME) begin
      @(negedge clk);
      w++;
    end
    n_chk++;
    if (!(m_pos == FRAME - 1) || upd_ready !== 1'b1)
      $display("FAIL coll_setup got pos=%0d ready=%b exp pos=%0d ready=1",
               m_pos, upd_ready, FRAME - 1);
    else n_pass++;
    upd_data = $urandom;
    upd_pwm = 3'($urandom_range(1, 7));
    upd_valid = 1'b1;
    @(negedge clk);
    upd_valid = 1'b0;
    for (int j = 0; j <= FRAME + 2 * SLOT; j++) begin
      if (j <= FRAME) begin
        n_chk++;
        if (upd_ready !== (j == FRAME))
          $display("FAIL coll_ready j=%0d got=%b exp=%b", j, upd_ready, (j == FRAME));
        else n_pass++;
      end
      n_chk++;
      if ({frame_start, upd_ready, led_col, led_row} !== {e_fs, m_ready, e_col, e_row})
        $display("FAIL coll_model got=%h exp=%h t=%0t",
                 {frame_start, upd_ready, led_col, led_row}, {e_fs, m_ready, e_col, e_row}, $time);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_enable();
    int w, s1, cnt;
    logic [3:0] prev, k;
    en = 1'b1;
    prev = led_col;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while ((led_col === prev || led_col === 4'hF) && w < 2 * FRAME);
    k = led_col;
    s1 = 1;
    repeat (5) begin
      @(negedge clk);
      if (led_col === k) s1++;
    end
    en = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_chk++;
      if ({frame_start, upd_ready, led_col, led_row} !== {e_fs, m_ready, e_col, e_row})
        $display("FAIL en_off got=%h exp=%h t=%0t",
                 {frame_start, upd_ready, led_col, led_row}, {e_fs, m_ready, e_col, e_row}, $time);
      else n_pass++;
    end
    en = 1'b1;
    cnt = 0;
    for (int i = 0; i < 2 * SLOT; i++) begin
      @(negedge clk);
      n_chk++;
      if ({frame_start, upd_ready, led_col, led_row} !== {e_fs, m_ready, e_col, e_row})
        $display("FAIL en_resume got=%h exp=%h t=%0t",
                 {frame_start, upd_ready, led_col, led_row}, {e_fs, m_ready, e_col, e_row}, $time);
      else n_pass++;
      if (led_col === k) cnt++;
      else break;
    end
    n_chk++;
    if (cnt !== SLOT - s1)
      $display("FAIL en_slot_rest got=%0d exp=%0d", cnt, SLOT - s1);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      n_chk++;
      if ({frame_start, upd_ready, led_col, led_row} !== {e_fs, m_ready, e_col, e_row})
        $display("FAIL rand got=%h exp=%h t=%0t",
                 {frame_start, upd_ready, led_col, led_row}, {e_fs, m_ready, e_col, e_row}, $time);
      else n_pass++;
      en = ($urandom_range(0, 9) != 0);
      if (!upd_valid || m_acc) begin
        upd_valid = ($urandom_range(0, 3) == 0);
        upd_data = $urandom;
        upd_pwm = 3'($urandom);
      end
    end
    upd_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_scan();
    test_pwm();
    test_backpressure();
    test_collision();
    test_enable();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
